apb_slave_mem_responder: RTL and testbench
==========================================

# apb_slave_mem_responder

Synthesizable APB completer (slave) that terminates APB transfers from the master agent or DUT fabric, backing them with a word-addressed local memory. It samples the SETUP phase, inserts a programmable number of wait states, commits byte-strobed writes, returns read data, and flags errors on PSLVERR. It is the responder end of the APB link and is instantiated once per slave select line (one `pselx` bit).

## Interface
Parameters:
- ADDRESS_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width; must be 32 in this version, so pstrb is 4 bits
- MEM_DEPTH, 256, memory depth in DATA_WIDTH words; power of two
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- pclk  in  1  APB clock; all logic is updated on the rising edge.
- preset_n  in  1  synchronous active-low reset.
- psel  in  1  this slave's select bit.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read (tx_type_e).
- paddr  in  ADDRESS_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte-lane enables.
- pprot  in  3  protection (protection_type_e).
- cfg_wait_states  in  4  wait states to insert; sampled at the SETUP edge.
- cfg_secure_only  in  1  when 1, reject non-secure accesses (pprot[1]=1).
- pready  out  1  transfer completion.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response (slave_error_e).

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: on a rising edge with psel=1 and penable=0, latch pwrite, paddr, pwdata, pstrb, and the error decode. Load wait_cnt with cfg_wait_states, then go to ACCESS. psel=1 with penable=1 while in IDLE is ignored.
- ACCESS: while wait_cnt≠0, decrement it each edge. On the edge where wait_cnt=0, register pready=1, pslverr, and prdata (for reads), then return to IDLE.
- Write commit: occurs at the edge where pready=1, psel=1 and penable=1 are sampled, and only if the latched error is 0. Only lanes with pstrb[i]=1 are written. pstrb=0 is legal and writes nothing, with no error.
- Error decode (OR of the following conditions):
  - paddr < BASE_ADDR or paddr ≥ BASE_ADDR + MEM_DEPTH*4
  - paddr[1:0]≠0
  - cfg_secure_only=1 and pprot[1]=1
- On error: no memory update, prdata=0, pslverr=1.
- Word index is (paddr − BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits. pstrb is ignored on reads.
- Abort: psel=0 sampled in ACCESS before completion returns the FSM to IDLE. No write occurs and pready stays 0.
- cfg_* changes during ACCESS have no effect on the current transfer.

## Timing
- Reset (preset_n=0 at an edge): state=IDLE, wait_cnt=0, pready=0, prdata=0, pslverr=0. The latched command is discarded and there is no write. Memory contents are not reset.
- Access phase length is cfg_wait_states+1 cycles. With 0 waits, pready=1 in the first penable cycle, giving a 2-cycle transfer.
- pready is high for exactly one cycle per transfer.
- prdata and pslverr are nonzero only in the pready cycle; at all other times they are 0.
- Back-to-back transfers: a SETUP in the cycle immediately after the pready cycle is accepted, because the FSM is already in IDLE.
- Read-after-write to the same address in the next transfer returns the new data, since the write commits before the next SETUP edge.

## Structure
- The shared global package holds the following:
  - slave_error_e, protection_type_e, tx_type_e
  - new typedef apb_resp_state_e {IDLE, ACCESS}
  - constant APB_WAIT_CNT_WIDTH=4
- Sub-module apb_mem_array: MEM_DEPTH×DATA_WIDTH array with per-byte write enables and a combinational read port. The top level holds the FSM, wait counter, decode and output registers.

## Test plan
- Write 32'hDEADBEEF to BASE_ADDR+0x10 with pstrb=4'hF and 0 waits -> pready in the 1st access cycle, pslverr=0. Read-back -> prdata=32'hDEADBEEF, 2-cycle transfer.
- Preload 32'hAAAAAAAA, then write 32'h11223344 with pstrb=4'b0101 -> read returns 32'hAA22AA44.
- cfg_wait_states=3 read -> pready=0 for 3 access cycles and 1 in the 4th. prdata=0 before the 4th cycle.
- Write to BASE_ADDR+MEM_DEPTH*4, then to BASE_ADDR+0x2 -> pslverr=1 with pready in both; memory unchanged.
- cfg_secure_only=1, read with pprot=3'b010 -> pslverr=1, prdata=0. With pprot=3'b000 -> pslverr=0.
- cfg_wait_states=5 write, preset_n=0 in the 2nd access cycle -> next edge pready=0, IDLE; target word unchanged. A back-to-back write plus read immediately after completes normally.

Source files
------------

// File: rtl/apb_slave_mem_responder_pkg.sv
// rtl/apb_slave_mem_responder_pkg.sv - shared types and constants for the APB memory responder
package apb_slave_mem_responder_pkg;

    localparam int APB_WAIT_CNT_WIDTH = 4;
    localparam int PROT_NONSECURE_BIT = 1;

    typedef enum logic {
        SLV_OKAY  = 1'b0,
        SLV_ERROR = 1'b1
    } slave_error_e;

    typedef enum logic [2:0] {
        PROT_NORMAL_SECURE_DATA = 3'b000,
        PROT_PRIVILEGED         = 3'b001,
        PROT_NONSECURE          = 3'b010,
        PROT_INSTRUCTION        = 3'b100
    } protection_type_e;

    typedef enum logic {
        TX_READ  = 1'b0,
        TX_WRITE = 1'b1
    } tx_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_resp_state_e;

    // A non-secure access is flagged by the middle protection bit.
    function automatic logic is_nonsecure(input logic [2:0] prot);
        return prot[PROT_NONSECURE_BIT];
    endfunction

endpackage

// File: rtl/apb_slave_mem_responder_if.sv
// rtl/apb_slave_mem_responder_if.sv - APB bus bundle between requester and this responder
interface apb_slave_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_responder_mem_array.sv
// rtl/apb_slave_mem_responder_mem_array.sv - word array with byte-lane writes and combinational read
module apb_mem_array #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Commit only the enabled byte lanes; contents survive reset on purpose.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/apb_slave_mem_responder.sv
// rtl/apb_slave_mem_responder.sv - APB completer backed by local memory with wait states and error decode
module apb_slave_mem_responder
    import apb_slave_mem_responder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_DEPTH     = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [APB_WAIT_CNT_WIDTH-1:0] cfg_wait_states,
    input  logic                          cfg_secure_only,
    apb_slave_mem_responder_if.slave      apb
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] P_LIMIT =
        (ADDRESS_WIDTH+1)'(BASE_ADDR) + (ADDRESS_WIDTH+1)'(MEM_DEPTH * 4);

    apb_resp_state_e                r_state, w_state_next;
    logic [APB_WAIT_CNT_WIDTH-1:0]  r_wait_cnt, w_wait_cnt_next;
    tx_type_e                       r_write, w_write_next;
    logic [IDX_W-1:0]               r_index, w_index_next;
    logic [DATA_WIDTH-1:0]          r_wdata, w_wdata_next;
    logic [DATA_WIDTH/8-1:0]        r_strb, w_strb_next;
    slave_error_e                   r_err, w_err_next;
    logic                           r_pready, w_pready_next;
    logic [DATA_WIDTH-1:0]          r_prdata, w_prdata_next;
    logic                           r_pslverr, w_pslverr_next;

    logic [ADDRESS_WIDTH-1:0]       w_offset;
    logic [IDX_W-1:0]               w_setup_index;
    logic                           w_out_of_range;
    logic                           w_misaligned;
    logic                           w_prot_reject;
    slave_error_e                   w_err_decode;
    logic [IDX_W-1:0]               w_rd_index;
    logic [DATA_WIDTH-1:0]          w_mem_rdata;
    logic                           w_mem_we;
    logic                           w_complete;
    slave_error_e                   w_cmp_err;
    tx_type_e                       w_cmp_type;
    logic                           w_unused_bits;

    // Address decode of the SETUP-phase request.
    assign w_offset       = apb.paddr - BASE_ADDR;
    assign w_setup_index  = w_offset[IDX_W+1:2];
    assign w_out_of_range = (apb.paddr < BASE_ADDR) || ({1'b0, apb.paddr} >= P_LIMIT);
    assign w_misaligned   = (apb.paddr[1:0] != 2'b00);
    assign w_prot_reject  = cfg_secure_only && is_nonsecure(apb.pprot);
    assign w_err_decode   = slave_error_e'(w_out_of_range || w_misaligned || w_prot_reject);
    assign w_unused_bits  = ^{w_offset[ADDRESS_WIDTH-1:IDX_W+2], w_offset[1:0],
                              apb.pprot[2], apb.pprot[0]};

    // With zero wait states the read completes at the SETUP edge, so read from the live address then.
    assign w_rd_index = (r_state == IDLE) ? w_setup_index : r_index;

    // Writes land on the completion edge, only for a clean, still-selected transfer.
    assign w_mem_we = (r_state == ACCESS) && r_pready && apb.psel && apb.penable &&
                      (r_err == SLV_OKAY) && (r_write == TX_WRITE);

    apb_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_mem_we),
        .i_waddr (r_index),
        .i_wstrb (r_strb),
        .i_wdata (r_wdata),
        .i_raddr (w_rd_index),
        .o_rdata (w_mem_rdata)
    );

    // Next-state, wait counter, command latch and one-cycle response outputs.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_write_next    = r_write;
        w_index_next    = r_index;
        w_wdata_next    = r_wdata;
        w_strb_next     = r_strb;
        w_err_next      = r_err;
        w_pready_next   = 1'b0;
        w_prdata_next   = '0;
        w_pslverr_next  = 1'b0;
        w_complete      = 1'b0;
        w_cmp_err       = r_err;
        w_cmp_type      = r_write;

        case (r_state)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    w_state_next    = ACCESS;
                    w_wait_cnt_next = cfg_wait_states;
                    w_write_next    = tx_type_e'(apb.pwrite);
                    w_index_next    = w_setup_index;
                    w_wdata_next    = apb.pwdata;
                    w_strb_next     = apb.pstrb;
                    w_err_next      = w_err_decode;
                    if (cfg_wait_states == '0) begin
                        w_complete = 1'b1;
                        w_cmp_err  = w_err_decode;
                        w_cmp_type = tx_type_e'(apb.pwrite);
                    end
                end
            end
            ACCESS: begin
                if (r_pready) begin
                    w_state_next = IDLE;
                end else if (!apb.psel) begin
                    w_state_next    = IDLE;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt != '0) begin
                    w_wait_cnt_next = r_wait_cnt - 1'b1;
                    if (r_wait_cnt == APB_WAIT_CNT_WIDTH'(1)) begin
                        w_complete = 1'b1;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_complete) begin
            w_pready_next  = 1'b1;
            w_pslverr_next = (w_cmp_err == SLV_ERROR);
            if ((w_cmp_err == SLV_OKAY) && (w_cmp_type == TX_READ)) begin
                w_prdata_next = w_mem_rdata;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_write    <= TX_READ;
            r_index    <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_err      <= SLV_OKAY;
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_write    <= w_write_next;
            r_index    <= w_index_next;
            r_wdata    <= w_wdata_next;
            r_strb     <= w_strb_next;
            r_err      <= w_err_next;
            r_pready   <= w_pready_next;
            r_prdata   <= w_prdata_next;
            r_pslverr  <= w_pslverr_next;
        end
    end

    assign apb.pready  = r_pready;
    assign apb.prdata  = r_prdata;
    assign apb.pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// tb/tb_apb_slave_mem_responder.sv - randomized scoreboard bench for the APB memory responder
module tb_apb_slave_mem_responder;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic       clk = 1'b0;
    logic       preset_n = 1'b0;
    logic [3:0] cfg_wait_states = 4'd0;
    logic       cfg_secure_only = 1'b0;

    apb_slave_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_mem_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (DEPTH),
        .BASE_ADDR     (BASE)
    ) dut (
        .pclk            (clk),
        .preset_n        (preset_n),
        .cfg_wait_states (cfg_wait_states),
        .cfg_secure_only (cfg_secure_only),
        .apb             (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        is_read;
        bit        err;
        bit [31:0] rdata;
        int        lat;
    } sb_t;

    sb_t       sb[$];
    bit [31:0] mem_m [DEPTH];
    int        n_assert = 0;
    int        n_fail   = 0;
    int        acc_cnt  = 0;
    bit [31:0] last_rdata;
    bit        last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input bit [31:0] a, input bit [2:0] prot, input bit sec);
        longint la = longint'(a);
        if (la < longint'(BASE) || la >= longint'(BASE) + DEPTH * 4) return 1'b1;
        if (a % 4 != 0) return 1'b1;
        if (sec && prot[1]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic xfer(input bit [31:0] addr, input bit wr, input bit [31:0] wdata,
                        input bit [3:0] strb, input bit [2:0] prot, input int waits, input bit sec);
        sb_t e;
        int  idx;
        bit  got = 0;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
        bus.pwdata = wdata; bus.pstrb = strb; bus.pprot = prot;
        cfg_wait_states = 4'(waits); cfg_secure_only = sec;
        e.err = model_err(addr, prot, sec);
        e.is_read = !wr;
        e.lat = waits + 1;
        e.rdata = 32'h0;
        if (!e.err) begin
            idx = int'((addr - BASE) / 4);
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) mem_m[idx][i*8 +: 8] = wdata[i*8 +: 8];
            end else begin
                e.rdata = mem_m[idx];
            end
        end
        sb.push_back(e);
        @(posedge clk); #1;
        bus.penable = 1'b1;
        cfg_wait_states = 4'($urandom);
        cfg_secure_only = 1'($urandom);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.pready) begin got = 1; break; end
        end
        if (!got) chk("pready_timeout", 64'(got), 64'd1);
    endtask

    task automatic abort_xfer(input bit [31:0] addr, input bit wr, input int waits);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
        bus.pwdata = $urandom; bus.pstrb = 4'hF; bus.pprot = 3'b000;
        cfg_wait_states = 4'(waits); cfg_secure_only = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the responder completes a transfer.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!preset_n) begin
                acc_cnt = 0;
            end else if (bus.pready) begin
                acc_cnt++;
                chk("pready_in_access", 64'(bus.psel && bus.penable), 64'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_pready", 64'(bus.pready), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pslverr", 64'(bus.pslverr), 64'(e.err));
                    chk("latency", 64'(acc_cnt), 64'(e.lat));
                    if (e.is_read) chk("prdata", 64'(bus.prdata), 64'(e.rdata));
                    last_rdata = bus.prdata;
                    last_err   = bus.pslverr;
                end
                acc_cnt = 0;
            end else begin
                chk("idle_prdata_zero", 64'(bus.prdata), 64'd0);
                chk("idle_pslverr_zero", 64'(bus.pslverr), 64'd0);
                if (bus.psel && bus.penable) acc_cnt++;
                else acc_cnt = 0;
            end
        end
    end

    initial begin
        bit [31:0] a, old_a, d;
        int        r;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0;
        bus.pwdata = 0; bus.pstrb = 0; bus.pprot = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pready", 64'(bus.pready), 64'd0);
        chk("reset_prdata", 64'(bus.prdata), 64'd0);
        chk("reset_pslverr", 64'(bus.pslverr), 64'd0);
        @(posedge clk); #1;
        preset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) xfer(BASE + 32'(i * 4), 1, $urandom, 4'hF, 3'b000, 0, 0);

        xfer(BASE + 32'h10, 1, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0);
        xfer(BASE + 32'h10, 0, 32'h0, 4'hF, 3'b000, 0, 0);
        #2 chk("readback_deadbeef", 64'(last_rdata), 64'hDEADBEEF);

        xfer(BASE + 32'h20, 1, 32'hAAAAAAAA, 4'hF, 3'b000, 0, 0);
        xfer(BASE + 32'h20, 1, 32'h11223344, 4'b0101, 3'b000, 1, 0);
        xfer(BASE + 32'h20, 0, 32'h0, 4'h0, 3'b000, 0, 0);
        #2 chk("strobe_merge", 64'(last_rdata), 64'hAA22AA44);

        xfer(BASE + 32'h20, 1, 32'h55555555, 4'h0, 3'b000, 0, 0);
        xfer(BASE + 32'h20, 0, 32'h0, 4'h0, 3'b000, 3, 0);

        xfer(BASE + 32'(DEPTH * 4), 1, 32'h0BADF00D, 4'hF, 3'b000, 0, 0);
        #2 chk("err_above_limit", 64'(last_err), 64'd1);
        xfer(BASE + 32'h2, 1, 32'h0BADF00D, 4'hF, 3'b000, 0, 0);
        #2 chk("err_misaligned", 64'(last_err), 64'd1);
        xfer(BASE - 32'h4, 0, 32'h0, 4'hF, 3'b000, 2, 0);
        xfer(BASE + 32'h0, 0, 32'h0, 4'hF, 3'b000, 0, 0);

        xfer(BASE + 32'h10, 0, 32'h0, 4'hF, 3'b010, 0, 1);
        #2 chk("secure_reject", 64'(last_err), 64'd1);
        xfer(BASE + 32'h10, 0, 32'h0, 4'hF, 3'b000, 0, 1);
        #2 chk("secure_accept", 64'(last_err), 64'd0);

        repeat (2) @(posedge clk);
        idle();

        a = BASE + 32'h40;
        @(posedge clk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = a;
        bus.pwdata = 32'h12345678; bus.pstrb = 4'hF; bus.pprot = 3'b000;
        cfg_wait_states = 4'd5; cfg_secure_only = 0;
        @(posedge clk); #1;
        bus.penable = 1;
        @(posedge clk); #1;
        preset_n = 0;
        @(posedge clk); #1;
        preset_n = 1; bus.psel = 0; bus.penable = 0;
        @(negedge clk);
        chk("reset_abort_pready", 64'(bus.pready), 64'd0);
        xfer(BASE + 32'h44, 1, 32'hCAFEF00D, 4'hF, 3'b000, 0, 0);
        xfer(BASE + 32'h44, 0, 32'h0, 4'hF, 3'b000, 0, 0);
        xfer(a, 0, 32'h0, 4'hF, 3'b000, 0, 0);
        idle();

        abort_xfer(BASE + 32'h48, 1, 4);
        xfer(BASE + 32'h48, 0, 32'h0, 4'hF, 3'b000, 1, 0);
        idle();

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 19));
            if (r < 14)      a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            else if (r < 16) a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            else if (r < 18) a = BASE + DEPTH * 4 + 4 * $urandom_range(0, 63);
            else if (r < 19) a = BASE - 4 * $urandom_range(1, 64);
            else             a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                abort_xfer(a, 1'($urandom), int'($urandom_range(2, 6)));
            end else begin
                xfer(a, 1'($urandom), d, 4'($urandom), 3'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                     1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
